// File: rtl/bank_arbiter.sv
// Round-robin merge of a bank's node packet streams into one buffered stream toward the mesh router.
// Optional feature: define BANK_ARB_DONE_PRIORITY_EN to let CTRL_DONE packets pre-empt round-robin.
package bank_arbiter_pkg;

  localparam int NODES_PER_BANK = 4;

  typedef enum logic [1:0] {
    CTRL_NOP  = 2'd0,
    CTRL_SUM  = 2'd1,
    CTRL_DONE = 2'd2,
    CTRL_CFG  = 2'd3
  } ctrl_t;

  typedef struct packed {
    logic [7:0]  addr;
    ctrl_t       ctrl;
    logic [15:0] data;
  } pkt_t;

endpackage

module bank_arbiter
  import bank_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = NODES_PER_BANK,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] valid_in,
  output logic [NUM_PORTS-1:0] ready_in,
  input  pkt_t                 in_pkt [NUM_PORTS],
  output logic                 valid_out,
  input  logic                 ready_out,
  output pkt_t                 out_pkt
);

  localparam int PW = $clog2(NUM_PORTS);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic [PW-1:0] rr_ptr_r;
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  pkt_t          mem_r [FIFO_DEPTH];

  logic          found_s;
  logic          done_s;
  logic [PW-1:0] g_s;
  logic [PW:0]   idx_s;
  logic          full_s;
  logic          empty_s;
  logic          push_s;
  logic          pop_s;
  logic [PW-1:0] rr_next_s;

  assign full_s  = (count_r == CW'(FIFO_DEPTH));
  assign empty_s = (count_r == {CW{1'b0}});

  // Grant selection: round-robin scan from rr_ptr, optionally overridden by the lowest DONE requester.
  always_comb begin
    found_s = 1'b0;
    done_s  = 1'b0;
    g_s     = {PW{1'b0}};
    idx_s   = {(PW+1){1'b0}};
    for (int k = 0; k < NUM_PORTS; k++) begin
      idx_s = {1'b0, rr_ptr_r} + (PW+1)'(k);
      if (idx_s >= (PW+1)'(NUM_PORTS)) begin
        idx_s = idx_s - (PW+1)'(NUM_PORTS);
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && valid_in[idx_s[PW-1:0]]) begin
        found_s = 1'b1;
        g_s     = idx_s[PW-1:0];
      end else begin
        found_s = found_s;
      end
    end
`ifdef BANK_ARB_DONE_PRIORITY_EN
    // Descending scan so the lowest-indexed DONE requester wins.
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (valid_in[i] && (in_pkt[i].ctrl == CTRL_DONE)) begin
        done_s  = 1'b1;
        found_s = 1'b1;
        g_s     = PW'(i);
      end else begin
        done_s  = done_s;
      end
    end
`endif
  end

  // Handshake decode; full gating uses registered count so a pop never frees a slot in the same cycle.
  always_comb begin
    ready_in = {NUM_PORTS{1'b0}};
    push_s   = !rst && !full_s && found_s;
    pop_s    = !rst && !empty_s && ready_out;
    if (push_s) begin
      ready_in[g_s] = 1'b1;
    end else begin
      ready_in = {NUM_PORTS{1'b0}};
    end
    if (g_s == PW'(NUM_PORTS - 1)) begin
      rr_next_s = {PW{1'b0}};
    end else begin
      rr_next_s = g_s + PW'(1);
    end
  end

  // FIFO head presentation; zeroed when empty or in reset.
  always_comb begin
    valid_out = !rst && !empty_s;
    if (valid_out) begin
      out_pkt = mem_r[rd_ptr_r];
    end else begin
      out_pkt = '0;
    end
  end

  // Control state: arbitration pointer, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
        if (!done_s) begin
          rr_ptr_r <= rr_next_s;
        end
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Packet storage; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= in_pkt[g_s];
    end
  end

endmodule

// File: tb/tb_bank_arbiter.sv
// Directed self-checking bench for bank_arbiter with NUM_PORTS=4, FIFO_DEPTH=4.
module tb_bank_arbiter;
  import bank_arbiter_pkg::*;

  logic       clk;
  logic       rst;
  logic [3:0] valid_in;
  logic [3:0] ready_in;
  pkt_t       in_pkt [4];
  logic       valid_out;
  logic       ready_out;
  pkt_t       out_pkt;

  int errors = 0;
  int checks = 0;

  bank_arbiter #(.NUM_PORTS(4), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .in_pkt    (in_pkt),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .out_pkt   (out_pkt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic pkt_t mk(input int i);
    pkt_t p;
    p.addr = 8'(16 + i);
    p.ctrl = CTRL_SUM;
    p.data = 16'(40960 + i);
    return p;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_default();
    for (int i = 0; i < 4; i++) in_pkt[i] = mk(i);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  pkt_t done_pkt;

  initial begin
    rst = 1'b1;
    valid_in = 4'b1111;
    ready_out = 1'b1;
    load_default();

    // Reset held two cycles with all nodes requesting
    tick();
    tick();
    chk("rst_valid_out", 64'(valid_out), 64'd0);
    chk("rst_out_pkt", 64'(out_pkt), 64'd0);
    chk("rst_ready_in", 64'(ready_in), 64'd0);
    rst = 1'b0;
    #1;
    chk("first_grant", 64'(ready_in), 64'd1);

    // Round-robin with continuous valid and ready_out
    for (int k = 0; k < 6; k++) begin
      chk("rr_grant", 64'(ready_in), 64'(4'b0001 << (k % 4)));
      if (k > 0) begin
        chk("rr_valid", 64'(valid_out), 64'd1);
        chk("rr_pkt", 64'(out_pkt), 64'(mk((k - 1) % 4)));
      end
      tick();
    end
    chk("rr_ptr_after6", 64'(dut.rr_ptr_r), 64'd2);
    valid_in = 4'b0000;
    #1;
    chk("rr_last_pkt", 64'(out_pkt), 64'(mk(1)));
    tick();
    chk("rr_drained", 64'(valid_out), 64'd0);
    chk("rr_drained_pkt", 64'(out_pkt), 64'd0);

    // Full / backpressure
    do_reset();
    ready_out = 1'b0;
    valid_in = 4'b1111;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("fill_grant", 64'(ready_in), 64'(4'b0001 << k));
      tick();
    end
    chk("full_ready", 64'(ready_in), 64'd0);
    chk("full_count", 64'(dut.count_r), 64'd4);
    chk("full_head", 64'(out_pkt), 64'(mk(0)));
    tick();
    chk("full_hold_head", 64'(out_pkt), 64'(mk(0)));
    chk("full_hold_valid", 64'(valid_out), 64'd1);
    ready_out = 1'b1;
    #1;
    chk("pop_cycle_no_push", 64'(ready_in), 64'd0);
    tick();
    chk("after_pop_push", 64'(ready_in), 64'd1);
    chk("after_pop_head", 64'(out_pkt), 64'(mk(1)));
    chk("after_pop_count", 64'(dut.count_r), 64'd3);
    tick();
    valid_in = 4'b0000;
    #1;
    chk("drain_a", 64'(out_pkt), 64'(mk(2)));
    tick();
    chk("drain_b", 64'(out_pkt), 64'(mk(3)));
    tick();
    chk("drain_c", 64'(out_pkt), 64'(mk(0)));
    tick();
    chk("drain_empty", 64'(valid_out), 64'd0);

    // Single requestor
    do_reset();
    ready_out = 1'b1;
    valid_in = 4'b0100;
    #1;
    chk("single_grant", 64'(ready_in), 64'b0100);
    chk("single_no_valid", 64'(valid_out), 64'd0);
    tick();
    valid_in = 4'b0000;
    #1;
    chk("single_rr", 64'(dut.rr_ptr_r), 64'd3);
    chk("single_valid", 64'(valid_out), 64'd1);
    chk("single_pkt", 64'(out_pkt), 64'(mk(2)));
    tick();
    chk("single_empty", 64'(valid_out), 64'd0);

    // DONE priority contest
    do_reset();
    ready_out = 1'b0;
    done_pkt = mk(3);
    done_pkt.ctrl = CTRL_DONE;
    done_pkt.data = 16'd42;
    in_pkt[3] = done_pkt;
    valid_in = 4'b1011;
    #1;
`ifdef BANK_ARB_DONE_PRIORITY_EN
    chk("prio_grant", 64'(ready_in), 64'b1000);
`else
    chk("prio_grant", 64'(ready_in), 64'b0001);
`endif
    tick();
    valid_in = 4'b0000;
    #1;
`ifdef BANK_ARB_DONE_PRIORITY_EN
    chk("prio_rr", 64'(dut.rr_ptr_r), 64'd0);
    chk("prio_ctrl", 64'(out_pkt.ctrl), 64'(CTRL_DONE));
    chk("prio_data", 64'(out_pkt.data), 64'd42);
`else
    chk("prio_rr", 64'(dut.rr_ptr_r), 64'd1);
    chk("prio_pkt", 64'(out_pkt), 64'(mk(0)));
`endif
    load_default();

    // Reset mid-operation discards buffered packets
    do_reset();
    ready_out = 1'b0;
    valid_in = 4'b1111;
    tick();
    tick();
    tick();
    chk("mid_count3", 64'(dut.count_r), 64'd3);
    valid_in = 4'b0000;
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", 64'(ready_in), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("mid_valid", 64'(valid_out), 64'd0);
    chk("mid_count0", 64'(dut.count_r), 64'd0);
    chk("mid_pkt", 64'(out_pkt), 64'd0);
    in_pkt[2].data = 16'hBEEF;
    valid_in = 4'b0100;
    #1;
    chk("mid_push_grant", 64'(ready_in), 64'b0100);
    tick();
    valid_in = 4'b0000;
    #1;
    chk("mid_new_valid", 64'(valid_out), 64'd1);
    chk("mid_new_data", 64'(out_pkt.data), 64'hBEEF);
    ready_out = 1'b1;
    tick();
    chk("mid_no_stale", 64'(valid_out), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
